// File: rtl/data_sync_tx.sv
// Source-domain side of a four-phase level handshake that moves a registered word
// to an asynchronous destination domain; bus_ack is brought in through a flop chain.

module data_sync_tx #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] unsync_bus,
   output logic                  bus_enable,
   input  logic                  bus_ack,
   output logic                  busy,
   output logic                  done_pulse
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StReq     = 2'd1,
      StRelease = 2'd2
   } state_e;

   state_e                state_q;
   logic [NUM_STAGES-1:0] ack_sync_q;
   logic                  ack_s;

   // Only the last stage is observed; earlier stages exist to settle metastability.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_sync_q <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], bus_ack};
      end
   end

   assign ack_s = ack_sync_q[NUM_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         unsync_bus <= '0;
         bus_enable <= 1'b0;
         busy       <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // ack_s is deliberately ignored here; a stale or spurious ack must not
               // advance the handshake.
               if (in_valid) begin
                  unsync_bus <= in_data;
                  bus_enable <= 1'b1;
                  busy       <= 1'b1;
                  state_q    <= StReq;
               end
            end
            StReq: begin
               if (ack_s) begin
                  bus_enable <= 1'b0;
                  state_q    <= StRelease;
               end
            end
            StRelease: begin
               if (!ack_s) begin
                  busy       <= 1'b0;
                  done_pulse <= 1'b1;
                  state_q    <= StIdle;
               end
            end
            default: begin
               bus_enable <= 1'b0;
               busy       <= 1'b0;
               state_q    <= StIdle;
            end
         endcase
      end
   end

   assign in_ready = (state_q == StIdle);

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx: directed handshake/latency scenarios plus a randomized run,
// with captured words and completion counts checked by an independent monitor.

module tb_data_sync_tx;

   localparam int unsigned DW = 8;
   localparam int unsigned NS = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] unsync_bus;
   logic          bus_enable;
   logic          bus_ack;
   logic          busy;
   logic          done_pulse;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            done_seen = 0;
   int            exp_done = 0;
   int            last_done_cyc = -10;
   logic [DW-1:0] exp_q[$];
   bit            auto_ack = 1'b0;

   data_sync_tx #(
      .DATA_WIDTH(DW),
      .NUM_STAGES(NS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .unsync_bus(unsync_bus),
      .bus_enable(bus_enable),
      .bus_ack   (bus_ack),
      .busy      (busy),
      .done_pulse(done_pulse)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a word and hold it until a handshake edge; returns the cycle of acceptance.
   task automatic send_word(input logic [DW-1:0] d, input bit keep, output int acc_cyc);
      bit acc;
      bit ok = 1'b0;
      in_data  = d;
      in_valid = 1'b1;
      exp_q.push_back(d);
      for (int i = 0; i < 500; i++) begin
         acc = in_ready;
         tick();
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      acc_cyc = cyc;
      if (!keep) in_valid = 1'b0;
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (!busy && !bus_enable && !bus_ack) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 32'd0, 32'd1);
      tick();
   endtask

   // Destination-side responder: follows bus_enable with a random delay.
   initial begin
      int dly = 0;
      forever begin
         tick();
         if (auto_ack && rst_n) begin
            if (bus_enable != bus_ack) begin
               if (dly == 0) begin
                  bus_ack = bus_enable;
                  dly     = $urandom_range(0, 3);
               end else begin
                  dly--;
               end
            end
         end
      end
   end

   // Monitor: pops the expected word on each new request and checks it is held.
   initial begin
      bit            prev_en = 1'b0;
      bit            prev_done = 1'b0;
      logic [DW-1:0] held = '0;
      logic [DW-1:0] exp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_en   = 1'b0;
            prev_done = 1'b0;
         end else begin
            if (bus_enable && !prev_en) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_capture: got 0x%0h expected no request", unsync_bus);
               end else begin
                  exp  = exp_q.pop_front();
                  held = exp;
                  check("capture", 32'(unsync_bus), 32'(exp));
               end
            end else if (busy) begin
               check("bus_hold", 32'(unsync_bus), 32'(held));
            end
            check("ready_vs_busy", 32'(in_ready), 32'(!busy));
            if (done_pulse) begin
               done_seen++;
               last_done_cyc = cyc;
               check("done_single", 32'(prev_done), 32'd0);
            end
            prev_en   = bus_enable;
            prev_done = done_pulse;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc1;
      int acc2;
      int gap;

      rst_n    = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;
      bus_ack  = 1'b0;

      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_bus_enable", 32'(bus_enable), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_unsync_bus", 32'(unsync_bus), 32'd0);
      check("rst_done", 32'(done_pulse), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single capture of 0xA5.
      send_word(8'hA5, 1'b0, acc1);
      check("a5_bus", 32'(unsync_bus), 32'hA5);
      check("a5_enable", 32'(bus_enable), 32'd1);
      check("a5_ready", 32'(in_ready), 32'd0);
      check("a5_busy", 32'(busy), 32'd1);

      // New word offered while busy must not be captured.
      in_data  = 8'h3C;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("busy_ignore_bus", 32'(unsync_bus), 32'hA5);
         check("busy_ignore_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;

      // Ack latency through the synchronizer, both phases.
      bus_ack = 1'b1;
      for (int i = 1; i <= int'(NS) + 1; i++) begin
         tick();
         check("req_to_release", 32'(bus_enable), 32'(i < int'(NS) + 1));
      end
      tick();
      bus_ack = 1'b0;
      for (int i = 1; i <= int'(NS) + 2; i++) begin
         tick();
         check("done_timing", 32'(done_pulse), 32'(i == int'(NS) + 1));
         check("busy_timing", 32'(busy), 32'(i < int'(NS) + 1));
      end
      exp_done++;
      check("after_done_ready", 32'(in_ready), 32'd1);

      // Spurious ack in idle.
      bus_ack = 1'b1;
      for (int i = 0; i < int'(NS) + 7; i++) begin
         if (i == 5) bus_ack = 1'b0;
         tick();
         check("idle_ack_ready", 32'(in_ready), 32'd1);
         check("idle_ack_enable", 32'(bus_enable), 32'd0);
         check("idle_ack_done", 32'(done_pulse), 32'd0);
         check("idle_ack_bus", 32'(unsync_bus), 32'hA5);
      end

      // Back-to-back words with valid held throughout.
      auto_ack = 1'b1;
      send_word(8'h01, 1'b1, acc1);
      send_word(8'h02, 1'b0, acc2);
      gap = acc2 - last_done_cyc;
      check("b2b_gap", 32'(gap), 32'd1);
      wait_idle();
      exp_done += 2;
      check("b2b_done_count", 32'(done_seen), 32'(exp_done));

      // Reset during the release phase aborts without a completion pulse.
      auto_ack = 1'b0;
      send_word(8'hC3, 1'b0, acc1);
      bus_ack = 1'b1;
      for (int i = 0; i < 20 && bus_enable; i++) tick();
      check("reached_release", 32'(bus_enable), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_enable", 32'(bus_enable), 32'd0);
      check("abort_bus", 32'(unsync_bus), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(in_ready), 32'd1);
      check("abort_done", 32'(done_pulse), 32'd0);
      bus_ack = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("abort_no_done", 32'(done_seen), 32'(exp_done));
      auto_ack = 1'b1;
      send_word(8'h5A, 1'b0, acc1);
      wait_idle();
      exp_done++;
      check("post_reset_done", 32'(done_seen), 32'(exp_done));

      // Randomized traffic.
      for (int n = 0; n < 25; n++) begin
         send_word(DW'($urandom), 1'($urandom_range(0, 1)), acc1);
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            in_valid = 1'b0;
            repeat (gap) tick();
         end
      end
      in_valid = 1'b0;
      wait_idle();
      exp_done += 25;

      check("final_done_count", 32'(done_seen), 32'(exp_done));
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
